// File: rtl/load_data_unit_pkg.sv
// Shared definitions for the load path: MIPS load/store opcodes, FSM states and access sizes,
// plus helpers that classify an opcode and derive the byte lanes it touches.
package load_data_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  // SZ_NONE marks anything that is not a load, including stores.
  function automatic size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU: return SZ_BYTE;
      OP_LH, OP_LHU: return SZ_HALF;
      OP_LW:         return SZ_WORD;
      default:       return SZ_NONE;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_data_unit_extender.sv
// Combinational lane select plus sign/zero extension of a memory word for a MIPS load.
// No state, zero latency; unknown opcodes yield 0.
module load_extender
  import load_data_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [5:0]  i_opcode,
  output logic [31:0] o_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = i_word[{i_offset, 3'b000} +: 8];
  assign sel_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = 32'd0;
    case (i_opcode)
      OP_LB:   o_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  o_data = {24'd0, sel_byte};
      OP_LH:   o_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  o_data = {16'd0, sel_half};
      OP_LW:   o_data = i_word;
      default: o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_data_unit.sv
// Load unit: accepts one load, issues a word read, waits for ack (bounded by TIMEOUT_CYCLES) and
// holds the extended result until i_rsp_ready; errors respond the cycle after accept, no memory access.
module load_data_unit
  import load_data_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_opcode,
  input  logic [31:0] i_memory_address,
  output logic        o_mem_rd,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_load_data,
  output logic        o_load_error
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  size_e       req_size;
  logic [31:0] ext_data;

  assign req_size = op_size(i_opcode);

  load_extender u_ext (
    .i_word   (i_mem_rdata),
    .i_offset (addr_q[1:0]),
    .i_opcode (op_q),
    .o_data   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          addr_d = i_memory_address;
          op_d   = i_opcode;
          cnt_d  = 8'd0;
          data_d = 32'd0;
          // Bad requests skip memory entirely and answer straight away.
          if (req_size == SZ_NONE || misaligned(req_size, i_memory_address[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ST_WAIT_MEM;
          end
        end
      end
      ST_WAIT_MEM: begin
        if (i_mem_ack) begin
          data_d  = ext_data;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = 32'd0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          data_d  = 32'd0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      op_q    <= 6'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready  = (state_q == ST_IDLE);
  assign o_mem_rd     = (state_q == ST_WAIT_MEM);
  assign o_mem_addr   = o_mem_rd ? {addr_q[31:2], 2'b00} : 32'd0;
  assign o_mem_be     = o_mem_rd ? byte_enables(op_size(op_q), addr_q[1:0]) : 4'b0000;
  assign o_rsp_valid  = (state_q == ST_RESP);
  assign o_load_data  = o_rsp_valid ? data_q : 32'd0;
  assign o_load_error = o_rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_load_data_unit.sv
// Randomized and directed stimulus for load_data_unit; responses are checked by a scoreboard
// fed from an arithmetic reference model of MIPS load semantics.
module tb_load_data_unit;

  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [5:0]  i_opcode;
  logic [31:0] i_memory_address;
  logic        o_mem_rd;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_load_data;
  logic        o_load_error;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] sb[$];

  load_data_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_opcode(i_opcode), .i_memory_address(i_memory_address),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_load_data(o_load_data), .o_load_error(o_load_error)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bytes accessed by a load opcode, 0 for anything that is not a load.
  function automatic int op_bytes(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100100: return 1;
      6'b100001, 6'b100101: return 2;
      6'b100011:            return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return (op == 6'b100000) || (op == 6'b100001);
  endfunction

  // Reference result {error, data}.
  function automatic logic [32:0] ref_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] w, input bit acked);
    int sz;
    longint v;
    longint span;
    sz = op_bytes(op);
    if (sz == 0 || (a % sz) != 0 || !acked) return {1'b1, 32'd0};
    span = longint'(1) << (8 * sz);
    v = (longint'(w) >> (8 * (a % 4))) % span;
    if (op_signed(op) && v >= span / 2) v = v - span;
    return {1'b0, 32'(v)};
  endfunction

  // Response monitor: pops one expectation per handshake.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1) begin
      if (!o_rsp_valid) check("data_zero_when_idle", 64'(o_load_data), 64'd0);
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'({o_load_error, o_load_data}), 64'h1_FFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("rsp", 64'({o_load_error, o_load_data}), 64'(e));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(o_req_ready), 64'd1);
    check({tag, "_ctrl"}, 64'({o_mem_rd, o_mem_be, o_rsp_valid, o_load_error}), 64'd0);
    check({tag, "_addr"}, 64'(o_mem_addr), 64'd0);
    check({tag, "_data"}, 64'(o_load_data), 64'd0);
  endtask

  // ack_at: WAIT_MEM cycle (1-based) carrying the ack; values outside 1..TO mean no ack.
  task automatic do_txn(input logic [5:0] op, input logic [31:0] a, input int ack_at,
                        input logic [31:0] rd, input int hold);
    int sz;
    bit bad;
    bit acked;
    int rd_cycles;
    int guard;
    logic [32:0] exp;
    logic [3:0]  exp_be;
    guard = 0;
    while (!o_req_ready && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    check("req_ready_before_accept", 64'(o_req_ready), 64'd1);
    sz = op_bytes(op);
    bad = (sz == 0) || ((a % sz) != 0);
    acked = (ack_at >= 1 && ack_at <= TO);
    exp = bad ? {1'b1, 32'd0} : ref_load(op, a, rd, acked);
    i_req_valid = 1'b1;
    i_opcode = op;
    i_memory_address = a;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_opcode = 6'($urandom);
    i_memory_address = $urandom;
    sb.push_back(exp);
    if (bad) begin
      check("err_no_mem_rd", 64'(o_mem_rd), 64'd0);
      check("err_rsp_immediate", 64'(o_rsp_valid), 64'd1);
    end else begin
      rd_cycles = 0;
      exp_be = 4'(((1 << sz) - 1) << (a % 4));
      for (int c = 1; c <= TO; c++) begin
        if (o_mem_rd) rd_cycles++;
        if (c == 1) begin
          check("mem_addr", 64'(o_mem_addr), 64'(a & 32'hFFFF_FFFC));
          check("mem_be", 64'(o_mem_be), 64'(exp_be));
        end
        i_mem_ack = (c == ack_at);
        i_mem_rdata = (c == ack_at) ? rd : $urandom;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        i_mem_rdata = $urandom;
        if (c == ack_at) break;
      end
      check("mem_rd_cycles", 64'(rd_cycles), 64'(acked ? ack_at : TO));
      check("mem_rd_low_in_resp", 64'(o_mem_rd), 64'd0);
      check("rsp_valid", 64'(o_rsp_valid), 64'd1);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); #1;
      check("hold_data", 64'({o_rsp_valid, o_load_error, o_load_data}), 64'({1'b1, exp}));
      check("hold_req_ready_low", 64'(o_req_ready), 64'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    check("idle_after_handshake", 64'({o_rsp_valid, o_req_ready}), 64'b01);
  endtask

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011,
                         LBU = 6'b100100, LHU = 6'b100101, SB = 6'b101000, SW = 6'b101011;

  initial begin
    logic [5:0] ops[8];
    ops = '{LB, LH, LW, LBU, LHU, SW, SB, 6'd0};
    i_rst_n = 1'b0;
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_req_valid = 1'($urandom);
      i_opcode = 6'($urandom);
      i_memory_address = $urandom;
      i_mem_ack = 1'($urandom);
      i_mem_rdata = $urandom;
      @(posedge i_clk); #1;
      check_reset_outputs("reset");
    end
    i_req_valid = 1'b0;
    i_mem_ack = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    do_txn(LW, 32'h100, 2, 32'hDEAD_BEEF, 0);
    do_txn(LB, 32'h203, 3, 32'h80FF_1234, 0);
    do_txn(LBU, 32'h203, 3, 32'h80FF_1234, 1);
    do_txn(LH, 32'h002, 1, 32'h8001_7FFF, 0);
    do_txn(LHU, 32'h000, 2, 32'h8001_7FFF, 0);
    do_txn(LW, 32'h105, 1, 32'h0, 0);
    do_txn(LH, 32'h101, 1, 32'h0, 0);
    do_txn(SW, 32'h100, 1, 32'h0, 0);
    do_txn(LW, 32'h040, 0, 32'h1111_2222, 0);
    // Late ack while idle must not produce a response.
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      check("late_ack_ignored", 64'({o_rsp_valid, o_mem_rd, o_req_ready}), 64'b001);
    end
    i_mem_ack = 1'b0;
    do_txn(LW, 32'h044, TO, 32'h1234_5678, 0);
    do_txn(LH, 32'h006, 2, 32'hF00F_0FF0, 5);

    // Reset in the middle of WAIT_MEM.
    i_req_valid = 1'b1;
    i_opcode = LW;
    i_memory_address = 32'h80;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    check("midreset_mem_rd_before", 64'(o_mem_rd), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h5555_AAAA;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    check("midreset_ack_ignored", 64'({o_rsp_valid, o_mem_rd, o_req_ready}), 64'b001);

    for (int t = 0; t < 300; t++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      if (op == 6'd0) op = 6'($urandom);
      do_txn(op, $urandom, $urandom_range(0, 6), $urandom, $urandom_range(0, 2));
    end

    repeat (3) @(posedge i_clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
